// File: rtl/demux_2to4_l1.sv
// Level-1 receive demux: two interleaved byte streams split into four byte lanes.
// Optional DEMUX_L1_REALIGN_EN: a fully invalid pair drops a slice back to UNALIGNED.

module demux_l1_slice (
    input  logic       clk_2f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic [7:0] data_even,
    output logic [7:0] data_odd,
    output logic       valid_even,
    output logic       valid_odd,
    output logic       aligned
);
    typedef enum logic {UNALIGNED = 1'b0, ALIGNED = 1'b1} state_t;

    state_t     state;
    logic       slot;
    logic [7:0] hold_d;
    logic       hold_v;

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            state      <= UNALIGNED;
            slot       <= 1'b0;
            hold_d     <= 8'h00;
            hold_v     <= 1'b0;
            data_even  <= 8'h00;
            data_odd   <= 8'h00;
            valid_even <= 1'b0;
            valid_odd  <= 1'b0;
            aligned    <= 1'b0;
        end else if (state == UNALIGNED) begin
            // The aligning byte occupies slot 0, so the next cycle is slot 1.
            if (valid_in) begin
                state   <= ALIGNED;
                aligned <= 1'b1;
                slot    <= 1'b1;
                hold_d  <= data_in;
                hold_v  <= 1'b1;
            end
        end else if (!slot) begin
            hold_d <= data_in;
            hold_v <= valid_in;
            slot   <= 1'b1;
        end else begin
            data_even  <= hold_d;
            valid_even <= hold_v;
            data_odd   <= data_in;
            valid_odd  <= valid_in;
            slot       <= 1'b0;
`ifdef DEMUX_L1_REALIGN_EN
            if (!hold_v && !valid_in) begin
                state   <= UNALIGNED;
                aligned <= 1'b0;
            end
`endif
        end
    end
endmodule

module demux_2to4_l1 (
    input  logic       clk_2f,
    input  logic       reset,
    input  logic [7:0] data_in1,
    input  logic       valid_in1,
    input  logic [7:0] data_in2,
    input  logic       valid_in2,
    output logic [7:0] data_out0,
    output logic [7:0] data_out1,
    output logic [7:0] data_out2,
    output logic [7:0] data_out3,
    output logic       valid_out0,
    output logic       valid_out1,
    output logic       valid_out2,
    output logic       valid_out3,
    output logic       aligned1,
    output logic       aligned2
);
    localparam int NUM_STREAMS = 2;

    logic [NUM_STREAMS-1:0][7:0] din;
    logic [NUM_STREAMS-1:0]      vin;
    logic [NUM_STREAMS-1:0][7:0] dev, dod;
    logic [NUM_STREAMS-1:0]      vev, vod, algn;

    assign din = {data_in2, data_in1};
    assign vin = {valid_in2, valid_in1};

    // Slices are fully independent; no cross-stream alignment is attempted.
    for (genvar s = 0; s < NUM_STREAMS; s++) begin : g_slice
        demux_l1_slice u_slice (
            .clk_2f    (clk_2f),
            .reset     (reset),
            .data_in   (din[s]),
            .valid_in  (vin[s]),
            .data_even (dev[s]),
            .data_odd  (dod[s]),
            .valid_even(vev[s]),
            .valid_odd (vod[s]),
            .aligned   (algn[s])
        );
    end

    assign data_out0  = dev[0];
    assign data_out1  = dod[0];
    assign data_out2  = dev[1];
    assign data_out3  = dod[1];
    assign valid_out0 = vev[0];
    assign valid_out1 = vod[0];
    assign valid_out2 = vev[1];
    assign valid_out3 = vod[1];
    assign aligned1   = algn[0];
    assign aligned2   = algn[1];
endmodule

// File: tb/tb_demux_2to4_l1.sv
// Directed bench for demux_2to4_l1: hand-written expected snapshots queued per step.
module tb_demux_2to4_l1;
    logic       clk_2f = 1'b0;
    logic       reset;
    logic [7:0] data_in1, data_in2;
    logic       valid_in1, valid_in2;
    logic [7:0] data_out0, data_out1, data_out2, data_out3;
    logic       valid_out0, valid_out1, valid_out2, valid_out3;
    logic       aligned1, aligned2;

    typedef struct packed {
        logic [3:0][7:0] d;
        logic [3:0]      v;
        logic [1:0]      a;
    } snap_t;

    snap_t exp_s;
    snap_t exp_q[$];
    int checks = 0;
    int errors = 0;

    demux_2to4_l1 dut (
        .clk_2f(clk_2f), .reset(reset),
        .data_in1(data_in1), .valid_in1(valid_in1),
        .data_in2(data_in2), .valid_in2(valid_in2),
        .data_out0(data_out0), .data_out1(data_out1),
        .data_out2(data_out2), .data_out3(data_out3),
        .valid_out0(valid_out0), .valid_out1(valid_out1),
        .valid_out2(valid_out2), .valid_out3(valid_out3),
        .aligned1(aligned1), .aligned2(aligned2)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic compare(input string tag);
        snap_t e;
        logic [31:0] od;
        logic [3:0]  ov;
        logic [1:0]  oa;
        e  = exp_q.pop_front();
        od = {data_out3, data_out2, data_out1, data_out0};
        ov = {valid_out3, valid_out2, valid_out1, valid_out0};
        oa = {aligned2, aligned1};
        checks += 3;
        assert (od === e.d) else begin
            errors++;
            $error("FAIL %s data observed=%h expected=%h", tag, od, e.d);
        end
        assert (ov === e.v) else begin
            errors++;
            $error("FAIL %s valid observed=%b expected=%b", tag, ov, e.v);
        end
        assert (oa === e.a) else begin
            errors++;
            $error("FAIL %s aligned observed=%b expected=%b", tag, oa, e.a);
        end
    endtask

    // Drive both streams and queue the snapshot expected after the next edge.
    task automatic drive(input logic [7:0] d1, input logic v1,
                         input logic [7:0] d2, input logic v2);
        data_in1 = d1; valid_in1 = v1;
        data_in2 = d2; valid_in2 = v2;
        exp_q.push_back(exp_s);
    endtask

    task automatic tick(input string tag);
        @(posedge clk_2f);
        #1;
        compare(tag);
    endtask

    initial begin
        reset = 1'b1;
        data_in1 = 8'h00; valid_in1 = 1'b0;
        data_in2 = 8'h00; valid_in2 = 1'b0;
        exp_s = '0;
        #2;
        exp_q.push_back(exp_s);
        compare("reset_state");
        @(posedge clk_2f); #3;
        reset = 1'b0;

        // Idle: 20 cycles with no valid bytes, nothing moves.
        for (int i = 0; i < 20; i++) begin
            drive(8'h5A, 1'b0, 8'hA5, 1'b0);
            tick("idle");
        end

        // Stream 1 aligns on 0xA1; stream 2 starts one cycle later.
        exp_s.a[0] = 1'b1;
        drive(8'hA1, 1'b1, 8'h00, 1'b0); tick("align1");
        exp_s.d[0] = 8'hA1; exp_s.d[1] = 8'hB2; exp_s.v[1:0] = 2'b11;
        exp_s.a[1] = 1'b1;
        drive(8'hB2, 1'b1, 8'h11, 1'b1); tick("pair_a1_b2");
        exp_s.d[2] = 8'h11; exp_s.d[3] = 8'h22; exp_s.v[3:2] = 2'b11;
        drive(8'hC3, 1'b1, 8'h22, 1'b1); tick("hold_pair_lane23");
        exp_s.d[0] = 8'hC3; exp_s.d[1] = 8'hD4;
        drive(8'hD4, 1'b1, 8'h00, 1'b0); tick("pair_c3_d4");

        // Invalid slot-0 byte on stream 1; stream 2 finishes a fully invalid pair.
        exp_s.d[2] = 8'h00; exp_s.d[3] = 8'h00; exp_s.v[3:2] = 2'b00;
`ifdef DEMUX_L1_REALIGN_EN
        exp_s.a[1] = 1'b0;
`endif
        drive(8'h55, 1'b0, 8'h00, 1'b0); tick("s2_invalid_pair");
        exp_s.d[0] = 8'h55; exp_s.d[1] = 8'h66; exp_s.v[1:0] = 2'b10;
        drive(8'h66, 1'b1, 8'h00, 1'b0); tick("even_invalid");

        // Reset between slot 0 (0x77) and slot 1 clears everything at once.
        drive(8'h77, 1'b1, 8'h00, 1'b0); tick("slot0_77");
        #2 reset = 1'b1;
        #1;
        exp_s = '0;
        exp_q.push_back(exp_s);
        compare("async_reset");
        #1 reset = 1'b0;
        exp_s.a[0] = 1'b1;
        drive(8'h88, 1'b1, 8'h00, 1'b0); tick("realign_88");
        exp_s.d[0] = 8'h88; exp_s.d[1] = 8'h99; exp_s.v[1:0] = 2'b11;
        drive(8'h99, 1'b1, 8'h00, 1'b0); tick("pair_88_99");

        // Two invalid cycles, one idle cycle, then 0x9A, 0xBC.
        drive(8'h00, 1'b0, 8'h00, 1'b0); tick("inv_slot0");
        exp_s.d[0] = 8'h00; exp_s.d[1] = 8'h00; exp_s.v[1:0] = 2'b00;
`ifdef DEMUX_L1_REALIGN_EN
        exp_s.a[0] = 1'b0;
`endif
        drive(8'h00, 1'b0, 8'h00, 1'b0); tick("inv_slot1");
        drive(8'h00, 1'b0, 8'h00, 1'b0); tick("idle_after_inv");
`ifdef DEMUX_L1_REALIGN_EN
        exp_s.a[0] = 1'b1;
`else
        exp_s.d[1] = 8'h9A; exp_s.v[1] = 1'b1;
`endif
        drive(8'h9A, 1'b1, 8'h00, 1'b0); tick("byte_9a");
`ifdef DEMUX_L1_REALIGN_EN
        exp_s.d[0] = 8'h9A; exp_s.d[1] = 8'hBC; exp_s.v[1:0] = 2'b11;
`endif
        drive(8'hBC, 1'b1, 8'h00, 1'b0); tick("byte_bc");
`ifndef DEMUX_L1_REALIGN_EN
        exp_s.d[0] = 8'hBC; exp_s.d[1] = 8'h00; exp_s.v[1:0] = 2'b01;
`endif
        drive(8'h00, 1'b0, 8'h00, 1'b0); tick("after_bc");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
